// File: rtl/seq_gen_pkg.sv
`default_nettype none
/* ============================================================
 * Module      : seq_gen_pkg
 * Description : Shared types and constants for the pattern generator.
 * Revision    : 1.0
 * ============================================================ */
package seq_gen_pkg;

    localparam int c_MAX_LEN = 16;
    localparam int c_HIT_W   = 8;
    localparam logic [c_HIT_W-1:0] c_HIT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_gen_shreg.sv
`default_nettype none
/* ============================================================
 * Module      : seq_gen_shreg
 * Description : Pattern register with down-counting bit index (MSB first).
 * Revision    : 1.0
 * ============================================================ */
module seq_gen_shreg
    import seq_gen_pkg::*;
#(
    parameter int MAX_LEN = c_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               reload,
    input  logic               shift,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    output logic               bit_out,
    output logic               last_bit
);

    localparam int c_IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_IDX_W-1:0] w_load_idx;
    logic [c_IDX_W-1:0] w_reload_idx;

    // len is already clamped to MAX_LEN, so len-1 always fits the index width
    assign w_load_idx   = (len == '0)   ? '0 : c_IDX_W'(len - LEN_W'(1));
    assign w_reload_idx = (r_len == '0) ? '0 : c_IDX_W'(r_len - LEN_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pat <= '0;
            r_len <= '0;
            r_idx <= '0;
        end else if (load) begin
            r_pat <= pat;
            r_len <= len;
            r_idx <= w_load_idx;
        end else if (reload) begin
            r_idx <= w_reload_idx;
        end else if (shift) begin
            r_idx <= r_idx - c_IDX_W'(1);
        end
    end

    assign bit_out  = r_pat[r_idx];
    assign last_bit = (r_idx == '0);

endmodule
`default_nettype wire

// File: rtl/seq_gen.sv
`default_nettype none
/* ============================================================
 * Module      : seq_gen
 * Description : Serial pattern generator with repeat/gap and hit counter.
 * Revision    : 1.0
 * ============================================================ */
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int MAX_LEN = c_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int GAP_W   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    input  logic [7:0]         reps,
    input  logic [GAP_W-1:0]   gap,
    input  logic               abort,
    input  logic               hit,
    output logic               Dout,
    output logic               En,
    output logic               busy,
    output logic               done,
    output logic [c_HIT_W-1:0] hit_cnt
);

    state_t             r_state;
    logic [7:0]         r_reps;
    logic [GAP_W-1:0]   r_gap;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [c_HIT_W-1:0] r_hit_cnt;

    logic [LEN_W-1:0]   w_len_clamp;
    logic               w_load;
    logic               w_reload;
    logic               w_shift;
    logic               w_bit;
    logic               w_last;
    logic               w_more;

    assign w_len_clamp = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    assign w_load      = (r_state == IDLE) && start;
    assign w_more      = (r_reps > 8'd1);
    // Restart the pattern either back-to-back or at the end of the gap
    assign w_reload    = !abort &&
                         (((r_state == SEND) && w_last && w_more && (r_gap == '0)) ||
                          ((r_state == GAP) && (r_gap_cnt == GAP_W'(1))));
    assign w_shift     = (r_state == SEND) && !w_last;

    seq_gen_shreg #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shreg (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (w_load),
        .reload   (w_reload),
        .shift    (w_shift),
        .pat      (pat),
        .len      (w_len_clamp),
        .bit_out  (w_bit),
        .last_bit (w_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_reps    <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_reps  <= (reps == 8'd0) ? 8'd1 : reps;
                        r_gap   <= gap;
                        r_state <= (w_len_clamp != '0) ? SEND : DONE;
                    end
                end
                SEND: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (w_last) begin
                        r_reps <= r_reps - 8'd1;
                        if (!w_more) begin
                            r_state <= DONE;
                        end else if (r_gap != '0) begin
                            r_state   <= GAP;
                            r_gap_cnt <= r_gap;
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (r_gap_cnt == GAP_W'(1)) begin
                        r_state <= SEND;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_cnt <= '0;
        end else if (w_load) begin
            r_hit_cnt <= '0;
        end else if (En && hit && (r_hit_cnt != c_HIT_MAX)) begin
            r_hit_cnt <= r_hit_cnt + c_HIT_W'(1);
        end
    end

    assign En      = (r_state == SEND);
    assign Dout    = En & w_bit;
    assign busy    = (r_state != IDLE);
    assign done    = (r_state == DONE);
    assign hit_cnt = r_hit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_gen.sv
`default_nettype none
/* ============================================================
 * Module      : tb_seq_gen
 * Description : Self-checking bench for seq_gen against a stream model.
 * Revision    : 1.0
 * ============================================================ */
module tb_seq_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [15:0] pat;
    logic [4:0]  len;
    logic [7:0]  reps;
    logic [3:0]  gap;
    logic        hit;
    logic        Dout;
    logic        En;
    logic        busy;
    logic        done;
    logic [7:0]  hit_cnt;

    int          hit_mode;
    logic        hit_rand;
    logic        det_hit;
    logic [3:0]  det_hist;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    seq_gen dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .pat     (pat),
        .len     (len),
        .reps    (reps),
        .gap     (gap),
        .abort   (abort),
        .hit     (hit),
        .Dout    (Dout),
        .En      (En),
        .busy    (busy),
        .done    (done),
        .hit_cnt (hit_cnt)
    );

    // Mealy 10011 detector model, sampling on the falling edge
    always @(negedge clk) begin
        if (!busy) begin
            det_hist <= 4'd0;
            det_hit  <= 1'b0;
        end else if (En) begin
            det_hit  <= ({det_hist, Dout} == 5'b10011);
            det_hist <= {det_hist[2:0], Dout};
        end else begin
            det_hit <= 1'b0;
        end
    end

    assign hit = (hit_mode == 0) ? hit_rand : ((hit_mode == 1) ? det_hit : 1'b1);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: random hit, 1: detector loopback, 2: hit forced high
    task automatic run_txn(input logic [15:0] p, input int l, input int r, input int g,
                           input int mode, input string tag);
        bit         en_q[$];
        bit         d_q[$];
        int         el;
        int         er;
        int         nhit;
        logic [4:0] w;
        el   = (l > 16) ? 16 : l;
        er   = (r == 0) ? 1 : r;
        nhit = 0;
        if (el > 0) begin
            for (int k = 0; k < er; k++) begin
                for (int b = el - 1; b >= 0; b--) begin
                    en_q.push_back(1'b1);
                    d_q.push_back(p[b]);
                end
                if (k < er - 1) begin
                    for (int z = 0; z < g; z++) begin
                        en_q.push_back(1'b0);
                        d_q.push_back(1'b0);
                    end
                end
            end
        end
        if (mode == 1) begin
            w = 5'd0;
            foreach (en_q[i]) begin
                if (en_q[i]) begin
                    w = {w[3:0], d_q[i]};
                    if (w == 5'b10011) nhit++;
                end
            end
        end
        @(negedge clk);
        hit_mode = mode;
        pat      = p;
        len      = l[4:0];
        reps     = r[7:0];
        gap      = g[3:0];
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        foreach (en_q[i]) begin
            check_val({tag, "_en"},   32'(En),   32'(en_q[i]));
            check_val({tag, "_dout"}, 32'(Dout), 32'(d_q[i]));
            check_val({tag, "_busy"}, 32'(busy), 32'd1);
            check_val({tag, "_done"}, 32'(done), 32'd0);
            hit_rand = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (en_q[i] && ((mode == 0 && hit_rand) || mode == 2)) nhit++;
            @(negedge clk);
        end
        hit_rand = 1'b0;
        check_val({tag, "_done_pulse"}, 32'(done), 32'd1);
        check_val({tag, "_done_en"},    32'(En),   32'd0);
        check_val({tag, "_done_busy"},  32'(busy), 32'd1);
        @(negedge clk);
        check_val({tag, "_idle_busy"}, 32'(busy),    32'd0);
        check_val({tag, "_idle_done"}, 32'(done),    32'd0);
        check_val({tag, "_idle_en"},   32'(En),      32'd0);
        check_val({tag, "_hits"},      32'(hit_cnt), 32'((nhit > 255) ? 255 : nhit));
    endtask

    initial begin
        logic [15:0] ab_pat;
        reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        pat      = '0;
        len      = '0;
        reps     = '0;
        gap      = '0;
        hit_mode = 0;
        hit_rand = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_dout", 32'(Dout),    32'd0);
        check_val("rst_en",   32'(En),      32'd0);
        check_val("rst_busy", 32'(busy),    32'd0);
        check_val("rst_done", 32'(done),    32'd0);
        check_val("rst_hits", 32'(hit_cnt), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_txn(16'b10011, 5, 1, 0, 0, "single");
        run_txn(16'b101, 3, 3, 2, 0, "rep_gap");
        run_txn(16'hABCD, 0, 2, 1, 0, "len0");
        run_txn(16'h0013, 5, 0, 1, 0, "reps0");
        run_txn(16'hF0A5, 20, 1, 0, 0, "len20");

        // Abort on 3rd bit of an 8-bit pattern; a start while busy is ignored
        ab_pat   = 16'h00B6;
        hit_mode = 0;
        @(negedge clk);
        pat = ab_pat; len = 5'd8; reps = 8'd1; gap = 4'd0; start = 1'b1; hit_rand = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("ab_b1", 32'(Dout), 32'(ab_pat[7]));
        pat = 16'h0000; len = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("ab_b2", 32'(Dout), 32'(ab_pat[6]));
        @(negedge clk);
        check_val("ab_b3", 32'(Dout), 32'(ab_pat[5]));
        check_val("ab_en3", 32'(En), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        hit_rand = 1'b0;
        check_val("ab_en",   32'(En),      32'd0);
        check_val("ab_busy", 32'(busy),    32'd0);
        check_val("ab_done", 32'(done),    32'd0);
        check_val("ab_hits", 32'(hit_cnt), 32'd3);
        @(negedge clk);
        check_val("ab_done2", 32'(done),    32'd0);
        check_val("ab_busy2", 32'(busy),    32'd0);
        check_val("ab_hits2", 32'(hit_cnt), 32'd3);

        // Reset asserted mid-gap
        @(negedge clk);
        pat = 16'h000D; len = 5'd4; reps = 8'd2; gap = 4'd3; start = 1'b1; hit_rand = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        hit_rand = 1'b0;
        check_val("gap_en",   32'(En),      32'd0);
        check_val("gap_busy", 32'(busy),    32'd1);
        check_val("gap_hits", 32'(hit_cnt), 32'd4);
        #2 reset_n = 1'b0;
        #1;
        check_val("mrst_dout", 32'(Dout),    32'd0);
        check_val("mrst_en",   32'(En),      32'd0);
        check_val("mrst_busy", 32'(busy),    32'd0);
        check_val("mrst_done", 32'(done),    32'd0);
        check_val("mrst_hits", 32'(hit_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_txn(16'h000D, 4, 1, 0, 0, "post_rst");

        run_txn(16'b10011, 5, 3, 0, 1, "loop");
        check_val("loop_hits3", 32'(hit_cnt), 32'd3);
        run_txn(16'hFFFF, 16, 20, 0, 2, "sat");
        check_val("sat_255", 32'(hit_cnt), 32'd255);

        for (int t = 0; t < 40; t++) begin
            run_txn(16'($urandom), int'($urandom_range(0, 20)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), 0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_gen.md
# seq_gen

Serial pattern generator that drives the `Din`/`En` inputs of the team's Mealy sequence detector, which samples on the falling edge of `clk`. A host loads a pattern of up to `MAX_LEN` bits, a repeat count and an inter-repeat gap. The block then streams the pattern MSB-first, one bit per cycle, on rising-edge-updated outputs. It also counts detector hits returned on `hit`, closing the loop for self-checking runs.

## Interface
- `MAX_LEN`, 16: maximum pattern length in bits.
- `LEN_W`, $clog2(MAX_LEN+1): width of `len`.
- `GAP_W`, 4: width of `gap`.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: load request; accepted only when `busy`=0.
- `pat` in MAX_LEN: pattern; bit `len-1` is sent first, bit 0 last.
- `len` in LEN_W: number of pattern bits; values above MAX_LEN clamp to MAX_LEN.
- `reps` in 8: number of transmissions; 0 is treated as 1.
- `gap` in GAP_W: idle cycles between transmissions (not after the last).
- `abort` in 1: synchronous cancel.
- `hit` in 1: detector output, sampled on the rising edge while `En`=1.
- `Dout` out 1: serial data, driven to the detector's `Din`.
- `En` out 1: data-valid, driven to the detector's `En`.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse at normal completion.
- `hit_cnt` out 8: saturating count of sampled hits.

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - `Dout`=`En`=0.
  - `start`=1 latches `pat`, the clamped `len`, the effective `reps` and `gap`, and clears `hit_cnt`.
  - Next state is SEND if the clamped len>0, otherwise DONE.
- SEND:
  - `En`=1; `Dout` = latched bit `bit_idx`, where `bit_idx` starts at len-1 and decrements each cycle.
  - When `bit_idx`=0:
    - Decrement the remaining-reps counter.
    - If more reps remain, go to GAP when gap>0, otherwise straight back to SEND with `bit_idx` reloaded to len-1 (back-to-back streams).
    - If no reps remain, go to DONE.
- GAP:
  - `En`=0, `Dout`=0 for exactly `gap` cycles.
  - Then SEND with `bit_idx`=len-1.
- DONE:
  - `done`=1 and `En`=0 for one cycle.
  - Then IDLE.
- `abort`=1 in SEND, GAP or DONE:
  - Next state is IDLE.
  - `done` is not pulsed, and `hit_cnt` is held.
  - `abort` has priority over all other transitions; it is ignored in IDLE.
- `start` while `busy`=1 is ignored; there is no queueing.
- `start` and `abort` together in IDLE: start wins.
- `hit_cnt` increments on a rising edge where `En`=1 and `hit`=1. It saturates at 255 and does not wrap.
- Reset (`reset_n`=0, asynchronous):
  - State goes to IDLE.
  - `Dout`=`En`=`busy`=`done`=0 and `hit_cnt`=0.
  - All latched fields are cleared.
  - This applies equally mid-SEND or mid-GAP; no partial completion is reported.

## Timing
- Every output is registered or decoded purely from registered state; none is combinational from inputs.
- `start` is accepted at rising edge k. The first bit is valid on `Dout`/`En` from edge k, stable through the falling edge of cycle k+1 where the detector samples it.
- Each bit is held exactly one cycle.
- `busy` rises at edge k and falls at the edge that leaves DONE.
- Total SEND+GAP cycles = reps·len + (reps−1)·gap.
- `done` is high in the cycle immediately after the last bit. The next `start` can be accepted one cycle after `done`.
- `hit` arising from the last bit is sampled at the edge ending that bit's cycle and is counted.

## Structure
- Package `seq_gen_pkg` holds:
  - the state enum (IDLE, SEND, GAP, DONE);
  - the `MAX_LEN` default;
  - the hit-counter width and saturation constant.
- One sub-module, `seq_gen_shreg`. It holds the pattern register and the down-counting `bit_idx`, with reload and select. It outputs the current bit and `last_bit`.
- The top-level module holds the FSM, the reps and gap counters, and the hit counter.

## Test plan
- **Single pattern:** pat=5'b10011, len=5, reps=1, gap=0.
  - `Dout` = 1,0,0,1,1 with `En`=1 for 5 cycles, then `done` for 1 cycle.
  - `busy` is high for 6 cycles.
- **Repeats with gap:** pat=3'b101, len=3, reps=3, gap=2.
  - `En` pattern = 111 00 111 00 111; 13 SEND/GAP cycles, then `done`.
- **Edge values:**
  - len=0: `done` the cycle after accept, `En` never high.
  - reps=0: behaves as reps=1.
  - len=20 with MAX_LEN=16: exactly 16 bits sent.
- **Abort:** abort on the 3rd bit of an 8-bit pattern.
  - IDLE next cycle, `done` stays 0, `En`=0.
  - A `start` asserted during busy is ignored.
- **Reset:** `reset_n` low mid-GAP.
  - All outputs go to 0 immediately.
  - A fresh `start` after release streams from bit len-1.
- **Hit loopback:** loopback to the detector model with pattern 10011 and reps=3, gap=0.
  - `hit_cnt`=3.
  - Forcing `hit`=1 for 300 cycles saturates the count at 255.
